adder_bist_ctrl: RTL



---
 rtl/adder_bist_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/adder_bist_ctrl.sv
// BIST controller for a WIDTH-bit adder: sweeps every operand pair, checks each
// result against a golden sum, counts mismatches and captures the first failing vector.
module adder_bist_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic [WIDTH-1:0]   sum_in,
  input  logic               cout_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_cnt,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic [2:0]         dbg_state
);

  // start is a level request: it is honoured only while busy is low (IDLE or DONE);
  // the sweep then runs to completion regardless of start, with done marking completion.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [WIDTH-1:0] OP_MAX    = '1;
  localparam logic [WIDTH-1:0] OP_ONE    = WIDTH'(1);
  localparam logic [2*WIDTH:0] ERR_ONE   = (2*WIDTH+1)'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*WIDTH:0]   err_q, err_d;
  logic               fv_q, fv_d;
  logic [WIDTH-1:0]   fa_q, fa_d;
  logic [WIDTH-1:0]   fb_q, fb_d;

  logic [WIDTH:0]     golden;
  logic               mismatch;

  assign golden   = {1'b0, a_q} + {1'b0, b_q};
  assign mismatch = (cout_in != golden[WIDTH]) || (sum_in != golden[WIDTH-1:0]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          a_d     = '0;
          b_d     = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
        end
      end
      S_APPLY: begin
        cnt_d   = SETTLE_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
          end
        end
        // B is the inner loop; the last vector leaves both operands at max
        if (a_q == OP_MAX && b_q == OP_MAX) begin
          state_d = S_DONE;
        end else begin
          b_d     = b_q + OP_ONE;
          if (b_q == OP_MAX) a_d = a_q + OP_ONE;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign busy       = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (err_q == '0);
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
  assign dbg_state  = state_q;

endmodule
